// File: rtl/srl_fifo_ctrl_if.sv
// rtl/srl_fifo_ctrl_if.sv - write/read stream handshake bundle for srl_fifo_ctrl
interface srl_fifo_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [AW:0]      count;

    // Producer/consumer side: drives writes and read acceptance, observes flags.
    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  count
    );

    // FIFO side.
    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output count
    );
endinterface

// File: rtl/srl_fifo_ctrl.sv
// rtl/srl_fifo_ctrl.sv - shift-register FIFO with occupancy counter as the read tap address
module srl_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    srl_fifo_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    // Storage deliberately has no reset and a single shift path so it maps to SRL primitives.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      count;
    logic [AW-1:0]    rd_addr;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    // Flags depend only on the registered count, never on in_valid/out_ready.
    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    // Oldest entry sits at mem[count-1]; at count==DEPTH the low bits wrap to 0,
    // so the subtraction lands on DEPTH-1 as intended.
    assign rd_addr = count[AW-1:0] - AW'(1);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem[rd_addr];
    assign bus.count     = count;

    // Shift chain: every accepted write enters at mem[0] and pushes older words up.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[0] <= bus.in_data;
            for (int k = 1; k < DEPTH; k++) begin
                mem[k] <= mem[k-1];
            end
        end
    end

    // Occupancy: flush wins, push+pop holds, otherwise step up or down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + (AW+1)'(1);
        end else if (pop && !push) begin
            count <= count - (AW+1)'(1);
        end
    end
endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb/tb_srl_fifo_ctrl.sv - scoreboard bench for srl_fifo_ctrl
module tb_srl_fifo_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    srl_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    srl_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb[$];
    bit m_push;
    bit m_pop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue; acceptance decided from its own size.
    always @(posedge clk) begin
        if (!rst) begin
            if (clr) begin
                sb.delete();
            end else begin
                m_push = bus.in_valid && (sb.size() < DEPTH);
                m_pop  = bus.out_ready && (sb.size() > 0);
                if (m_pop) void'(sb.pop_front());
                if (m_push) sb.push_back(bus.in_data);
            end
        end
    end

    // Monitor: compare flags, count and head word mid-cycle.
    always @(negedge clk) begin
        check("count", bus.count, sb.size());
        check("in_ready", bus.in_ready, sb.size() != DEPTH);
        check("out_valid", bus.out_valid, sb.size() != 0);
        if (sb.size() > 0) check("out_data", bus.out_data, sb[0]);
    end

    // Apply inputs for the coming edge, return just after the next negedge.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit c);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        clr           = c;
        @(negedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] exp_seq [5];
    int pv;
    int pr;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Async reset mid-cycle with data queued
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("rst_count", bus.count, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Fill and drain
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_count", bus.count, 16);
        check("fill_in_ready", bus.in_ready, 0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        check("fill_17th_rejected", bus.count, 16);
        for (int i = 1; i <= 16; i++) begin
            check("drain_data", bus.out_data, i);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain_count", bus.count, 0);
        check("drain_out_valid", bus.out_valid, 0);

        // Streaming
        step(1'b1, 8'hA0, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            check("stream_count", bus.count, 1);
            check("stream_data", bus.out_data, 8'hA0 + k - 1);
            step(1'b1, 8'(8'hA0 + k), 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check("stream_empty", bus.count, 0);

        // Simultaneous push+pop at count 5
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        check("pp_pre_count", bus.count, 5);
        step(1'b1, 8'h99, 1'b1, 1'b0);
        check("pp_count", bus.count, 5);
        exp_seq[0] = 8'h12; exp_seq[1] = 8'h13; exp_seq[2] = 8'h14;
        exp_seq[3] = 8'h15; exp_seq[4] = 8'h99;
        for (int i = 0; i < 5; i++) begin
            check("pp_order", bus.out_data, exp_seq[i]);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("pp_empty", bus.count, 0);

        // Full boundary: push+pop offered while full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        check("full_count", bus.count, 16);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        check("full_pop_count", bus.count, 15);
        check("full_pop_in_ready", bus.in_ready, 1);
        for (int i = 1; i < 16; i++) begin
            check("full_drain", bus.out_data, 8'h20 + i);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("full_drain_empty", bus.count, 0);

        // Flush with same-cycle push at count 7
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        check("clr_pre_count", bus.count, 7);
        step(1'b1, 8'h33, 1'b1, 1'b1);
        check("clr_count", bus.count, 0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h5B, 1'b0, 1'b0);
        check("clr_after_count", bus.count, 2);
        check("clr_after_5a", bus.out_data, 8'h5A);
        step(1'b0, '0, 1'b1, 1'b0);
        check("clr_after_5b", bus.out_data, 8'h5B);
        step(1'b0, '0, 1'b1, 1'b0);

        // Async reset at count 9 mid-stream
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        check("rst9_pre_count", bus.count, 9);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h70;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #2;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        sb.delete();
        #1;
        check("rst9_count", bus.count, 0);
        check("rst9_out_valid", bus.out_valid, 0);
        check("rst9_in_ready", bus.in_ready, 1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h5B, 1'b0, 1'b0);
        check("rst9_after_5a", bus.out_data, 8'h5A);
        step(1'b0, '0, 1'b1, 1'b0);
        check("rst9_after_5b", bus.out_data, 8'h5B);
        step(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic with biased phases to reach full and empty
        for (int ph = 0; ph < 6; ph++) begin
            pv = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
            pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
            for (int n = 0; n < 300; n++) begin
                step($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pr,
                     $urandom_range(0, 199) == 0);
            end
        end

        step(1'b0, '0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/srl_fifo_ctrl.md
Name: srl_fifo_ctrl

Overview:
- Valid/ready FIFO built on a single shift-register storage array plus an occupancy counter that acts as the read address.
- Storage shifts on every accepted write and is never reset, so synthesis maps it onto SRL16E/SRLC32E primitives with clock enable and dynamic address.
- The controller sequences that datapath: it gates the shift enable, drives the tap address, and generates the handshakes and flags.
- Used wherever a shallow elastic buffer is needed between streaming stages in Xilinx-targeted designs.

Parameters:
- WIDTH, 8, data bits per entry.
- DEPTH, 16, number of entries; power of two, 2..64.
- AW, $clog2(DEPTH), localparam; tap address width.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset of all control state.
- clr  input  1  synchronous flush; empties the FIFO at the next edge.
- in_data  input  WIDTH  write data.
- in_valid  input  1  write request.
- in_ready  output  1  FIFO can accept data this cycle.
- out_data  output  WIDTH  oldest entry.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer accepts out_data.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: count=0, out_valid=0, in_ready=1. These apply immediately on rst assertion, without waiting for a clock edge.
- Storage contents are not reset and are don't-care after reset; a bench must not check them.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Data transfers only on a cycle where the handshake is true at the rising edge.
- Flags, purely from count:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - No combinational path from in_valid or out_ready to either flag.
- Storage:
  - On push, mem[0] <= in_data and mem[k] <= mem[k-1] for k = 1..DEPTH-1, all in one cycle.
  - No shift occurs without a push; shift enable = push.
  - The storage array has no reset and no other write path.
- Read: out_data = mem[count-1], a combinational dynamic-address read. When count=0, out_data is don't-care.
- Count update (priority order):
  - clr: count <= 0. A same-cycle push still shifts storage, but that data is discarded. A same-cycle pop is ignored.
  - push & pop: count unchanged. The oldest entry leaves and the new entry enters at mem[0].
  - push only: count + 1.
  - pop only: count - 1.
  - neither: hold.
- Latency:
  - A word pushed into an empty FIFO appears on out_data with out_valid=1 on the cycle after the push edge.
  - No same-cycle bypass.
- Full boundary: at count=DEPTH, in_ready=0, so no push is possible even when a pop is in progress. No simultaneous push+pop when full. A pop when full frees a slot for the following cycle.
- Empty boundary: at count=0, out_valid=0, so no pop is possible. A push when empty gives count=1 next cycle.
- Wrap-around: the count cannot overflow or underflow because of the gating above. No modular arithmetic is involved.
- Ordering: strict FIFO order is preserved under any interleaving of push, pop and stalls.
- Reset mid-operation: all queued data is lost; count=0 asynchronously. Operation resumes on the first clk edge after rst deasserts.
- Synthesis requirement: with WIDTH=8 and DEPTH=16, the design must map to 8 SRL16E for storage plus flops/LUTs for control. No storage bits may land in FDRE/FDCE.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst mid-cycle.
  - Required: count=0, out_valid=0, in_ready=1 before the next clk edge.
- Fill and drain:
  - Stimulus: push 0x01..0x10 with out_ready=0, then raise out_ready.
  - Required: count reaches 16 and in_ready=0 after the 16th push; a 17th in_valid is not accepted.
  - Required: out_data sequence 0x01..0x10, one per cycle; count returns to 0 and out_valid=0.
- Streaming:
  - Stimulus: in_valid=1 and out_ready=1 continuously with data 0xA0, 0xA1, ...
  - Required: after a 1-cycle startup, count stays 1 and output matches input delayed by one cycle.
- Simultaneous push+pop at count=5:
  - Stimulus: contents 0x11..0x15, push 0x99.
  - Required: count stays 5; out_data becomes 0x12; 0x99 emerges 5th after that.
- Full boundary:
  - Stimulus: at count=16, in_valid=1 and out_ready=1 for one cycle.
  - Required: only the pop occurs; count=15, in_ready=1 next cycle, incoming word is not stored.
- Flush and async reset:
  - clr with push at count=7: count=0 next cycle.
  - rst pulse at count=9 mid-stream: count=0 immediately.
  - Required in both cases: subsequent pushes 0x5A, 0x5B read back in order.
